// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the oversampled SPI receiver.
//   SYNC_STAGES   - depth of the input synchronizer chains
//   rx_state_e    - receiver frame state (IDLE / RECV)
//   sample_rising - 1 when data is sampled on the rising sck edge
package spi_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } rx_state_e;

   // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
   function automatic logic sample_rising(input logic cpol, input logic cpha);
      return cpol == cpha;
   endfunction

endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock show-ahead FIFO.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write request and data (ignored when full unless popping too)
//   full         pDepth words stored
//   pop          pop request (ignored when empty)
//   rdata        head word; holds the last popped word while empty, 0 after reset
//   empty        no words stored
//   level        words stored, 0..pDepth
module fifo_sync #(
   parameter int pWidth = 8,
   parameter int pDepth = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [pWidth-1:0]          wdata,
   output logic                       full,
   input  logic                       pop,
   output logic [pWidth-1:0]          rdata,
   output logic                       empty,
   output logic [$clog2(pDepth+1)-1:0] level
);

   localparam int AW = $clog2(pDepth);
   localparam int LW = $clog2(pDepth+1);

   logic [pWidth-1:0] mem_q [pDepth];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]     level_q;
   logic [pWidth-1:0] last_q;
   logic              do_push, do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LW'(pDepth));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         last_q   <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            last_q   <= mem_q[rd_ptr_q];
         end
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset: it is only read while the FIFO holds data.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = empty ? last_q : mem_q[rd_ptr_q];
   assign level = level_q;

endmodule

// File: rtl/spi_rx_oversampled.sv
// spi_rx_oversampled: SPI peripheral receiver clocked by the system clock.
// sck/csn/sdi are oversampled (clk >= 4x sck), words are assembled in any SPI
// mode, MSB- or LSB-first, and buffered in a show-ahead FIFO.
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   spi_sck, spi_csn, spi_sdi  asynchronous SPI pins
//   data, valid, ready         FIFO head word / not empty / pop on valid&&ready
//   level                      words stored, 0..pDepth
//   overrun, frame_err         sticky error flags
//   err_clr                    clears both sticky flags
// Optional feature macro SPI_RX_ERR_EN: when defined, overrun/frame_err are
// live sticky flags; when undefined they are tied to 0 and err_clr is ignored.
module spi_rx_oversampled
   import spi_pkg::*;
#(
   parameter int pBits     = 8,
   parameter int pDepth    = 4,
   parameter int pCpol     = 0,
   parameter int pCpha     = 0,
   parameter int pLsbFirst = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        spi_sck,
   input  logic                        spi_csn,
   input  logic                        spi_sdi,
   output logic [pBits-1:0]            data,
   output logic                        valid,
   input  logic                        ready,
   output logic [$clog2(pDepth+1)-1:0] level,
   output logic                        overrun,
   output logic                        frame_err,
   input  logic                        err_clr
);

   localparam int   CW       = $clog2(pBits);
   localparam logic kIdleSck = 1'(pCpol);
   localparam logic kRise    = sample_rising(1'(pCpol), 1'(pCpha));
   localparam logic kLsb     = (pLsbFirst != 0);

   // Synchronizers reset to idle pin levels so reset release is edge-free.
   logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, sdi_sync_q;
   logic                   sck_hist_q, csn_hist_q;
   logic                   sck_s, csn_s, sdi_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q <= {SYNC_STAGES{kIdleSck}};
         csn_sync_q <= '1;
         sdi_sync_q <= '0;
         sck_hist_q <= kIdleSck;
         csn_hist_q <= 1'b1;
      end else begin
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
         csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
         sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
         sck_hist_q <= sck_s;
         csn_hist_q <= csn_s;
      end
   end

   assign sck_s = sck_sync_q[SYNC_STAGES-1];
   assign csn_s = csn_sync_q[SYNC_STAGES-1];
   assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

   logic sample_edge, csn_fall, csn_rise, sample;
   assign sample_edge = kRise ? (sck_s & ~sck_hist_q) : (~sck_s & sck_hist_q);
   assign csn_fall    = ~csn_s & csn_hist_q;
   assign csn_rise    = csn_s & ~csn_hist_q;

   // Frame state
   rx_state_e state_q, state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (csn_fall) state_d = RECV;
         RECV:    if (csn_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A sample coinciding with csn rising is dropped because csn_s is already high.
   assign sample = sample_edge && !csn_s && ((state_q == RECV) || csn_fall);

   // Bit counter and shift register
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [pBits-1:0] shift_q, shift_d, word;
   logic             push;

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      push    = 1'b0;
      word    = kLsb ? {sdi_s, shift_q[pBits-1:1]} : {shift_q[pBits-2:0], sdi_s};
      if (csn_s) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (sample) begin
         if (cnt_q == CW'(pBits-1)) begin
            push    = 1'b1;
            cnt_d   = '0;
            shift_d = '0;
         end else begin
            cnt_d   = cnt_q + CW'(1);
            shift_d = word;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

   // Output FIFO
   logic fifo_full, fifo_empty;

   fifo_sync #(
      .pWidth (pBits),
      .pDepth (pDepth)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (word),
      .full  (fifo_full),
      .pop   (ready),
      .rdata (data),
      .empty (fifo_empty),
      .level (level)
   );

   assign valid = ~fifo_empty;

`ifdef SPI_RX_ERR_EN
   logic overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic drop, frag;

   assign drop        = push && fifo_full && !(ready && !fifo_empty);
   assign frag        = csn_rise && (cnt_q != '0);
   // Set has priority over clear.
   assign overrun_d   = drop | (overrun_q & ~err_clr);
   assign frame_err_d = frag | (frame_err_q & ~err_clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
`else
   logic unused_err;
   assign unused_err = err_clr ^ fifo_full;
   assign overrun    = 1'b0;
   assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_oversampled.sv
// Bench for spi_rx_oversampled. Four receivers run side by side on the same
// word stream: mode 0 MSB, mode 1 MSB, mode 3 MSB, mode 2 LSB-first. They share
// csn/ready/err_clr, so one queue model covers all of them.
module tb_spi_rx_oversampled;

   localparam int NI = 4;
   localparam int H  = 4;   // sck half period in clk cycles
`ifdef SPI_RX_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam logic [NI-1:0] CPOL = 4'b1100;
   localparam logic [NI-1:0] CPHA = 4'b0110;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NI-1:0]   sck, sdi;
   logic            csn, ready, err_clr;
   logic [7:0]      d_data  [NI];
   logic [2:0]      d_level [NI];
   logic [NI-1:0]   d_valid, d_ovr, d_fe;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      spi_rx_oversampled #(
         .pBits     (8),
         .pDepth    (4),
         .pCpol     (int'(CPOL[g])),
         .pCpha     (int'(CPHA[g])),
         .pLsbFirst ((g == 3) ? 1 : 0)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .spi_sck   (sck[g]),
         .spi_csn   (csn),
         .spi_sdi   (sdi[g]),
         .data      (d_data[g]),
         .valid     (d_valid[g]),
         .ready     (ready),
         .level     (d_level[g]),
         .overrun   (d_ovr[g]),
         .frame_err (d_fe[g]),
         .err_clr   (err_clr)
      );
   end

   // Model: ordered word queue, last popped word, sticky flags
   logic [7:0] mq [$];
   logic [7:0] m_last;
   bit         m_ovr, m_fe, chk_en;
   int         vectors = 0, miscompares = 0;
   logic [7:0] tx [8];

   task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            check("valid", i, 32'(d_valid[i]), 32'(mq.size() != 0));
            check("level", i, 32'(d_level[i]), 32'(mq.size()));
            check("data", i, 32'(d_data[i]), 32'((mq.size() != 0) ? mq[0] : m_last));
            check("overrun", i, 32'(d_ovr[i]), 32'(m_ovr));
            check("frame_err", i, 32'(d_fe[i]), 32'(m_fe));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_push(input logic [7:0] w);
      if (mq.size() < 4) mq.push_back(w);
      else if (ERR_EN) m_ovr = 1'b1;
   endtask

   task automatic pop_one();
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      m_last = mq.pop_front();
   endtask

   task automatic drain();
      while (mq.size() != 0) pop_one();
      tick(2);
   endtask

   task automatic err_pulse();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      m_ovr = 1'b0;
      m_fe  = 1'b0;
      tick(2);
   endtask

   // Drive nbits of tx[] in one frame. Phase A: CPHA0 launches data (trailing
   // edge), CPHA1 leading edge + data. Phase B: sample edge for every mode.
   task automatic send(input int nbits, input bit raise_csn, input bit pop_last, input bit lat_chk);
      chk_en = 1'b0;
      csn = 1'b0;
      tick(H);
      for (int k = 0; k < nbits; k++) begin
         logic [7:0] w;
         int b;
         w = tx[k/8];
         b = k % 8;
         for (int i = 0; i < NI; i++) begin
            sdi[i] = (i == 3) ? w[b] : w[7-b];
            sck[i] = CPHA[i] ? ~CPOL[i] : CPOL[i];
         end
         tick(H);
         for (int i = 0; i < NI; i++) sck[i] = CPHA[i] ? CPOL[i] : ~CPOL[i];
         if (k == nbits-1 && (pop_last || lat_chk)) begin
            tick(2);
            if (lat_chk) check("lat_before", 0, 32'(d_valid), 32'h0);
            if (pop_last) ready = 1'b1;
            tick(1);
            ready = 1'b0;
            if (lat_chk) check("lat_valid", 0, 32'(d_valid), 32'hF);
            tick(H-3);
         end else begin
            tick(H);
         end
      end
      sck = CPOL;
      tick(H);
      if (raise_csn) begin
         csn = 1'b1;
         tick(8);
      end
   endtask

   initial begin
      sck = CPOL; sdi = '0; csn = 1'b1; ready = 1'b0; err_clr = 1'b0;
      chk_en = 1'b0; m_last = '0; m_ovr = 1'b0; m_fe = 1'b0;
      rst_n = 1'b0;
      tick(3);
      for (int i = 0; i < NI; i++) begin
         check("rst_data", i, 32'(d_data[i]), 32'h0);
         check("rst_level", i, 32'(d_level[i]), 32'h0);
      end
      check("rst_valid", 0, 32'(d_valid), 32'h0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      tick(4);

      // Single word, latency from final sample edge
      tx[0] = 8'hA5;
      send(8, 1'b1, 1'b0, 1'b1);
      model_push(8'hA5); chk_en = 1'b1; tick(2);
      check("a5_data", 0, 32'(d_data[0]), 32'hA5);
      check("a5_lsb_data", 3, 32'(d_data[3]), 32'hA5);
      check("a5_level", 0, 32'(d_level[0]), 32'd1);
      drain();

      // Two words back-to-back in one frame
      tx[0] = 8'h3C; tx[1] = 8'hC3;
      send(16, 1'b1, 1'b0, 1'b0);
      model_push(8'h3C); model_push(8'hC3); chk_en = 1'b1; tick(2);
      check("pair_level_m1", 1, 32'(d_level[1]), 32'd2);
      check("pair_head_m3", 2, 32'(d_data[2]), 32'h3C);
      pop_one(); tick(1);
      check("pair_second_m1", 1, 32'(d_data[1]), 32'hC3);
      drain();
      check("empty_holds_last", 2, 32'(d_data[2]), 32'hC3);
      check("drained_level", 2, 32'(d_level[2]), 32'd0);

      // Overrun: five words into a depth-4 FIFO
      tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44; tx[4] = 8'h55;
      send(40, 1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 5; j++) model_push(tx[j]);
      chk_en = 1'b1; tick(2);
      check("ovr_level", 0, 32'(d_level[0]), 32'd4);
      check("ovr_head", 0, 32'(d_data[0]), 32'h11);
      check("ovr_flag", 0, 32'(d_ovr[0]), 32'(ERR_EN));
      err_pulse();
      check("ovr_cleared", 0, 32'(d_ovr[0]), 32'h0);
      drain();

      // Partial word (5 bits), then a full frame
      tx[0] = 8'hF0;
      send(5, 1'b1, 1'b0, 1'b0);
      if (ERR_EN) m_fe = 1'b1;
      chk_en = 1'b1; tick(2);
      tx[0] = 8'h81;
      send(8, 1'b1, 1'b0, 1'b0);
      model_push(8'h81); chk_en = 1'b1; tick(2);
      check("fe_level", 1, 32'(d_level[1]), 32'd1);
      check("fe_data", 1, 32'(d_data[1]), 32'h81);
      check("fe_flag", 1, 32'(d_fe[1]), 32'(ERR_EN));
      err_pulse();
      drain();

      // Full FIFO with a pop on the cycle the 5th word is pushed
      tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h04; tx[3] = 8'h08;
      send(32, 1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++) model_push(tx[j]);
      chk_en = 1'b1; tick(2);
      tx[0] = 8'h10;
      send(8, 1'b1, 1'b1, 1'b0);
      m_last = mq.pop_front();
      model_push(8'h10);
      chk_en = 1'b1; tick(2);
      check("fullpop_level", 0, 32'(d_level[0]), 32'd4);
      check("fullpop_head", 0, 32'(d_data[0]), 32'h02);
      check("fullpop_no_ovr", 0, 32'(d_ovr[0]), 32'h0);
      drain();

      // ready while empty does nothing
      ready = 1'b1; tick(4); ready = 1'b0; tick(2);

      // Reset mid-word, then a clean frame
      tx[0] = 8'h77;
      send(8, 1'b1, 1'b0, 1'b0);
      model_push(8'h77); chk_en = 1'b1; tick(2);
      tx[0] = 8'hF0;
      send(4, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      for (int i = 0; i < NI; i++) begin
         check("midrst_data", i, 32'(d_data[i]), 32'h0);
         check("midrst_level", i, 32'(d_level[i]), 32'h0);
      end
      check("midrst_valid", 0, 32'(d_valid), 32'h0);
      mq.delete(); m_last = '0; m_ovr = 1'b0; m_fe = 1'b0;
      csn = 1'b1; sck = CPOL; sdi = '0;
      tick(3);
      rst_n = 1'b1;
      chk_en = 1'b1; tick(4);
      tx[0] = 8'h5A;
      send(8, 1'b1, 1'b0, 1'b0);
      model_push(8'h5A); chk_en = 1'b1; tick(2);
      check("post_rst_data", 3, 32'(d_data[3]), 32'h5A);
      check("post_rst_level", 0, 32'(d_level[0]), 32'd1);
      drain();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
